ppu_fb_writer: RTL and testbench

Downstream consumer of the PPU pixel stream. Each accepted 2-bit colour index is mapped through the BGP palette to a 2-bit shade. Shades are packed four to a byte and written into a double-buffered framebuffer RAM. The block tracks x/y position from PX_valid and PPU_MODE, and hands completed frames to a host/display reader through a ready/ack handshake.

---
 rtl/ppu_fb_writer_if.sv | 31 +++
 rtl/ppu_fb_writer.sv | 212 +++++++++++++++++++++
 tb/tb_ppu_fb_writer.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ppu_fb_writer_if.sv
// Signal bundle between the PPU pixel stream / frame reader (master) and the
// framebuffer writer (slave).
interface ppu_fb_writer_if;
   logic       LCD_ON;
   logic [1:0] PPU_MODE;
   logic [1:0] PX_OUT;
   logic       PX_valid;
   logic [7:0] BGP;
   logic       FB_WR;
   logic [13:0] FB_ADDR;
   logic [7:0] FB_DATA;
   logic       FRAME_READY;
   logic       FRONT_SEL;
   logic       FRAME_ACK;
   logic       ERR_CLR;
   logic       OVERRUN;
   logic       UNDERRUN;
   logic       FRAME_DROP;

   modport master (
      output LCD_ON, PPU_MODE, PX_OUT, PX_valid, BGP, FRAME_ACK, ERR_CLR,
      input  FB_WR, FB_ADDR, FB_DATA, FRAME_READY, FRONT_SEL,
             OVERRUN, UNDERRUN, FRAME_DROP
   );

   modport slave (
      input  LCD_ON, PPU_MODE, PX_OUT, PX_valid, BGP, FRAME_ACK, ERR_CLR,
      output FB_WR, FB_ADDR, FB_DATA, FRAME_READY, FRONT_SEL,
             OVERRUN, UNDERRUN, FRAME_DROP
   );
endinterface

// File: rtl/ppu_fb_writer.sv
// Palette-maps the PPU pixel stream, packs four shades per byte and writes them
// into a double-buffered framebuffer, handing finished frames to a reader.
module ppu_fb_writer #(
   parameter int LINE_PX        = 160,
   parameter int LINES          = 144,
   parameter int BYTES_PER_LINE = 40
) (
   input logic            clk,
   input logic            rst,
   ppu_fb_writer_if.slave bus
);

   localparam logic [7:0] X_END     = 8'(LINE_PX);
   localparam logic [7:0] Y_END     = 8'(LINES);
   localparam logic [5:0] LAST_BYTE = 6'(BYTES_PER_LINE - 1);

   typedef enum logic [1:0] {IDLE, ACTIVE, FLUSH} state_t;

   state_t      state_q, state_d;
   logic [7:0]  x_q, x_d, y_q, y_d, pack_q, pack_d;
   logic        back_q, back_d, front_sel_q, front_sel_d;
   logic        ready_q, ready_d, pend_q, pend_d;
   logic [1:0]  mode_prev_q;
   logic        wr_q, wr_d;
   logic [13:0] addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        ovr_q, ovr_d, und_q, und_d, drop_q, drop_d;
   logic        ovr_set, und_set, drop_set;

   logic        lcd, draw, vbl_rise, line_ok, ack_ready, fe_req;
   logic [1:0]  shade;
   logic [7:0]  y_inc;
   logic [12:0] row_base;
   logic [13:0] cur_addr;

   function automatic logic [1:0] pal(input logic [7:0] bgp, input logic [1:0] idx);
      case (idx)
         2'd0:    pal = bgp[1:0];
         2'd1:    pal = bgp[3:2];
         2'd2:    pal = bgp[5:4];
         default: pal = bgp[7:6];
      endcase
   endfunction

   // Left-justify the n shades held in the low bits, padding with shade 0.
   function automatic logic [7:0] pad_byte(input logic [7:0] p, input logic [1:0] n);
      case (n)
         2'd1:    pad_byte = {p[1:0], 6'b0};
         2'd2:    pad_byte = {p[3:0], 4'b0};
         2'd3:    pad_byte = {p[5:0], 2'b0};
         default: pad_byte = 8'h00;
      endcase
   endfunction

   assign lcd       = bus.LCD_ON;
   assign draw      = (bus.PPU_MODE == 2'd3);
   assign vbl_rise  = (bus.PPU_MODE == 2'd1) && (mode_prev_q != 2'd1);
   assign shade     = pal(bus.BGP, bus.PX_OUT);
   assign line_ok   = (y_q < Y_END);
   assign y_inc     = (y_q == 8'hFF) ? y_q : y_q + 8'd1;
   assign row_base  = 13'(y_q) * 13'(BYTES_PER_LINE);
   assign cur_addr  = {back_q, row_base + {7'd0, x_q[7:2]}};
   assign ack_ready = ready_q & ~bus.FRAME_ACK;
   assign fe_req    = vbl_rise | pend_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (draw) state_d = ACTIVE;
         ACTIVE:  if (!draw) state_d = (x_q == X_END) ? IDLE : FLUSH;
         FLUSH:   if (x_q[7:2] == LAST_BYTE) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!lcd) state_d = IDLE;
   end

   always_comb begin
      x_d         = x_q;
      y_d         = y_q;
      pack_d      = pack_q;
      wr_d        = 1'b0;
      addr_d      = addr_q;
      data_d      = data_q;
      back_d      = back_q;
      front_sel_d = front_sel_q;
      ready_d     = ack_ready;
      pend_d      = pend_q;
      ovr_set     = 1'b0;
      und_set     = 1'b0;
      drop_set    = 1'b0;

      case (state_q)
         ACTIVE: begin
            if (draw) begin
               if (bus.PX_valid) begin
                  if (x_q == X_END) begin
                     ovr_set = 1'b1;
                  end else begin
                     pack_d = {pack_q[5:0], shade};
                     x_d    = x_q + 8'd1;
                     if (x_q[1:0] == 2'd3 && line_ok) begin
                        wr_d   = 1'b1;
                        addr_d = cur_addr;
                        data_d = {pack_q[5:0], shade};
                     end
                  end
               end
            end else if (x_q == X_END) begin
               x_d = 8'd0;
               y_d = y_inc;
            end else begin
               und_set = 1'b1;
            end
         end
         FLUSH: begin
            // After the partial byte the shift register is empty, so the
            // remaining bytes of the line come out as zeros.
            wr_d   = line_ok;
            addr_d = cur_addr;
            data_d = pad_byte(pack_q, x_q[1:0]);
            pack_d = 8'd0;
            if (x_q[7:2] == LAST_BYTE) begin
               x_d = 8'd0;
               y_d = y_inc;
            end else begin
               x_d = {x_q[7:2] + 6'd1, 2'b00};
            end
         end
         default: ;
      endcase

      // A frame end seen while flushing is deferred until the cycle after the flush.
      if (fe_req && lcd) begin
         if (state_q == FLUSH || state_d == FLUSH) begin
            pend_d = 1'b1;
         end else begin
            pend_d = 1'b0;
            if (y_d == Y_END && !ack_ready) begin
               front_sel_d = back_q;
               back_d      = ~back_q;
               ready_d     = 1'b1;
            end else begin
               drop_set = 1'b1;
            end
            y_d = 8'd0;
         end
      end

      if (!lcd) begin
         x_d     = 8'd0;
         y_d     = 8'd0;
         pack_d  = 8'd0;
         wr_d    = 1'b0;
         pend_d  = 1'b0;
         ovr_set = 1'b0;
         und_set = 1'b0;
      end

      ovr_d  = ovr_set  | (ovr_q  & ~bus.ERR_CLR);
      und_d  = und_set  | (und_q  & ~bus.ERR_CLR);
      drop_d = drop_set | (drop_q & ~bus.ERR_CLR);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         x_q         <= 8'd0;
         y_q         <= 8'd0;
         pack_q      <= 8'd0;
         back_q      <= 1'b0;
         front_sel_q <= 1'b0;
         ready_q     <= 1'b0;
         pend_q      <= 1'b0;
         mode_prev_q <= 2'd0;
         wr_q        <= 1'b0;
         addr_q      <= 14'd0;
         data_q      <= 8'd0;
         ovr_q       <= 1'b0;
         und_q       <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         x_q         <= x_d;
         y_q         <= y_d;
         pack_q      <= pack_d;
         back_q      <= back_d;
         front_sel_q <= front_sel_d;
         ready_q     <= ready_d;
         pend_q      <= pend_d;
         mode_prev_q <= bus.PPU_MODE;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         data_q      <= data_d;
         ovr_q       <= ovr_d;
         und_q       <= und_d;
         drop_q      <= drop_d;
      end
   end

   assign bus.FB_WR       = wr_q;
   assign bus.FB_ADDR     = addr_q;
   assign bus.FB_DATA     = data_q;
   assign bus.FRAME_READY = ready_q;
   assign bus.FRONT_SEL   = front_sel_q;
   assign bus.OVERRUN     = ovr_q;
   assign bus.UNDERRUN    = und_q;
   assign bus.FRAME_DROP  = drop_q;

endmodule

// File: tb/tb_ppu_fb_writer.sv
// Directed bench for ppu_fb_writer: palette/packing vectors from a table, then
// hand-written line, frame and handshake sequences.
module tb_ppu_fb_writer;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ppu_fb_writer_if bus ();

   ppu_fb_writer #(.LINE_PX(160), .LINES(144), .BYTES_PER_LINE(40)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [13:0] addr;
      logic [7:0]  data;
      int          cyc;
   } wr_t;

   typedef struct {
      logic [7:0]  bgp;
      logic [7:0]  pat;
      logic [7:0]  exp_data;
      logic [13:0] exp_base;
   } vec_t;

   wr_t  wq[$];
   int   cyc = 0;
   int   grp_cyc[40];
   int   n_chk = 0;
   int   n_pass = 0;
   vec_t vt[5];

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (bus.FB_WR === 1'b1) wq.push_back('{bus.FB_ADDR, bus.FB_DATA, cyc});

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [13:0] wq_addr(input int j);
      return (j < wq.size()) ? wq[j].addr : 14'h3FFF;
   endfunction

   // Four pixel indices in pat, first pixel in [7:6], repeated across the line.
   task automatic send_line(input int npx, input logic [7:0] pat, input logic [7:0] bgp,
                            input int clr_at, input int tail);
      logic [7:0] p;
      bus.BGP = bgp;
      bus.PPU_MODE = 2'd3;
      step();
      for (int i = 0; i < npx; i++) begin
         p = pat << (2 * (i % 4));
         bus.PX_valid = 1'b1;
         bus.PX_OUT = p[7:6];
         bus.ERR_CLR = (i == clr_at);
         if (i % 4 == 3 && i < 160) grp_cyc[i/4] = cyc;
         step();
      end
      bus.PX_valid = 1'b0;
      bus.ERR_CLR = 1'b0;
      bus.PPU_MODE = 2'd0;
      repeat (tail) step();
   endtask

   task automatic frame();
      for (int l = 0; l < 144; l++) send_line(160, 8'h1B, 8'hE4, -1, 1);
   endtask

   task automatic vblank(input logic ack);
      bus.PPU_MODE = 2'd1;
      bus.FRAME_ACK = ack;
      step();
      bus.FRAME_ACK = 1'b0;
      bus.PPU_MODE = 2'd0;
      step();
   endtask

   task automatic err_clr();
      bus.ERR_CLR = 1'b1;
      step();
      bus.ERR_CLR = 1'b0;
   endtask

   initial begin
      #(95000 * 10);
      $display("FAIL watchdog: cycle budget exhausted at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      vt[0] = '{8'hE4, 8'h1B, 8'h1B, 14'd0};
      vt[1] = '{8'h1B, 8'h1B, 8'hE4, 14'd40};
      vt[2] = '{8'hFF, 8'hFF, 8'hFF, 14'd80};
      vt[3] = '{8'hE4, 8'hC2, 8'hC2, 14'd120};
      vt[4] = '{8'h9C, 8'h78, 8'hE4, 14'd160};

      rst = 1'b1;
      bus.LCD_ON = 1'b1;
      bus.PPU_MODE = 2'd0;
      bus.PX_OUT = 2'd0;
      bus.PX_valid = 1'b0;
      bus.BGP = 8'hE4;
      bus.FRAME_ACK = 1'b0;
      bus.ERR_CLR = 1'b0;
      step();
      step();
      rst = 1'b0;
      step();
      check("rst FB_WR",       32'(bus.FB_WR), 32'd0);
      check("rst FB_ADDR",     32'(bus.FB_ADDR), 32'd0);
      check("rst FB_DATA",     32'(bus.FB_DATA), 32'd0);
      check("rst FRAME_READY", 32'(bus.FRAME_READY), 32'd0);
      check("rst FRONT_SEL",   32'(bus.FRONT_SEL), 32'd0);
      check("rst flags",       32'({bus.OVERRUN, bus.UNDERRUN, bus.FRAME_DROP}), 32'd0);

      for (int v = 0; v < 5; v++) begin
         wq.delete();
         send_line(160, vt[v].pat, vt[v].bgp, -1, 1);
         check($sformatf("vec%0d count", v), 32'(wq.size()), 32'd40);
         for (int j = 0; j < wq.size() && j < 40; j++) begin
            check($sformatf("vec%0d data[%0d]", v, j), 32'(wq[j].data), 32'(vt[v].exp_data));
            check($sformatf("vec%0d addr[%0d]", v, j), 32'(wq[j].addr), 32'(vt[v].exp_base) + 32'(j));
            if (v == 0) check($sformatf("vec0 timing[%0d]", j), 32'(wq[j].cyc), 32'(grp_cyc[j] + 1));
         end
      end

      // Short DRAW: 6 pixels of index 3 on line 5.
      wq.delete();
      send_line(6, 8'hFF, 8'hFF, -1, 45);
      check("underrun count", 32'(wq.size()), 32'd40);
      for (int j = 0; j < wq.size() && j < 40; j++) begin
         check($sformatf("underrun addr[%0d]", j), 32'(wq[j].addr), 32'd200 + 32'(j));
         check($sformatf("underrun data[%0d]", j), 32'(wq[j].data),
               (j == 0) ? 32'hFF : (j == 1) ? 32'hF0 : 32'h00);
      end
      check("UNDERRUN set", 32'(bus.UNDERRUN), 32'd1);
      wq.delete();
      send_line(160, 8'h1B, 8'hE4, -1, 1);
      check("after underrun first addr", 32'(wq_addr(0)), 32'd240);

      // 161 pixels; ERR_CLR lands on the overrun pixel itself.
      wq.delete();
      send_line(161, 8'h1B, 8'hE4, 160, 1);
      check("overrun count", 32'(wq.size()), 32'd40);
      check("overrun last addr", 32'(wq_addr(39)), 32'd319);
      check("OVERRUN beats ERR_CLR", 32'(bus.OVERRUN), 32'd1);
      check("UNDERRUN cleared", 32'(bus.UNDERRUN), 32'd0);
      err_clr();
      check("OVERRUN cleared", 32'(bus.OVERRUN), 32'd0);

      // LCD off at x=50 with pixels still arriving.
      bus.PPU_MODE = 2'd3;
      step();
      for (int i = 0; i < 50; i++) begin
         bus.PX_valid = 1'b1;
         bus.PX_OUT = 2'(i % 4);
         step();
      end
      wq.delete();
      bus.LCD_ON = 1'b0;
      step();
      check("lcd off FB_WR", 32'(bus.FB_WR), 32'd0);
      repeat (4) step();
      check("lcd off no writes", 32'(wq.size()), 32'd0);
      bus.PX_valid = 1'b0;
      bus.PPU_MODE = 2'd0;
      bus.LCD_ON = 1'b1;
      step();
      send_line(160, 8'h1B, 8'hE4, -1, 1);
      check("lcd on first addr", 32'(wq_addr(0)), 32'd0);
      check("lcd on count", 32'(wq.size()), 32'd40);
      check("lcd FRAME_READY kept", 32'(bus.FRAME_READY), 32'd0);

      // One-line frame is dropped.
      vblank(1'b0);
      check("short frame DROP", 32'(bus.FRAME_DROP), 32'd1);
      check("short frame READY", 32'(bus.FRAME_READY), 32'd0);
      err_clr();

      wq.delete();
      frame();
      check("frameA count", 32'(wq.size()), 32'd5760);
      check("frameA first addr", 32'(wq_addr(0)), 32'd0);
      check("frameA last addr", 32'(wq_addr(5759)), 32'd5759);
      vblank(1'b0);
      check("frameA READY", 32'(bus.FRAME_READY), 32'd1);
      check("frameA FRONT_SEL", 32'(bus.FRONT_SEL), 32'd0);
      check("frameA DROP", 32'(bus.FRAME_DROP), 32'd0);

      wq.delete();
      frame();
      check("frameB last addr", 32'(wq_addr(5759)), 32'h2000 + 32'd5759);
      vblank(1'b0);
      check("frameB DROP", 32'(bus.FRAME_DROP), 32'd1);
      check("frameB FRONT_SEL", 32'(bus.FRONT_SEL), 32'd0);
      check("frameB READY", 32'(bus.FRAME_READY), 32'd1);
      err_clr();
      check("DROP cleared", 32'(bus.FRAME_DROP), 32'd0);

      wq.delete();
      frame();
      check("frameC first addr", 32'(wq_addr(0)), 32'h2000);
      vblank(1'b1);
      check("ack+swap DROP", 32'(bus.FRAME_DROP), 32'd0);
      check("ack+swap FRONT_SEL", 32'(bus.FRONT_SEL), 32'd1);
      check("ack+swap READY", 32'(bus.FRAME_READY), 32'd1);

      bus.FRAME_ACK = 1'b1;
      step();
      bus.FRAME_ACK = 1'b0;
      check("ack clears READY", 32'(bus.FRAME_READY), 32'd0);
      check("ack keeps FRONT_SEL", 32'(bus.FRONT_SEL), 32'd1);

      rst = 1'b1;
      #2;
      check("async rst FRONT_SEL", 32'(bus.FRONT_SEL), 32'd0);
      rst = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
